// File: rtl/ram_arbiter_ctrl_pkg.sv
// Shared definitions for the RAM arbiter/sequencer: state encoding, access size codes,
// word-offset width and alignment helpers.
package ram_arbiter_ctrl_pkg;

  localparam int unsigned DataBus     = 32;
  localparam int unsigned DataAddrBus = 32;
  localparam int unsigned WordOffW    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  localparam logic [1:0] SzB   = 2'b00;
  localparam logic [1:0] SzH   = 2'b01;
  localparam logic [1:0] SzW   = 2'b10;
  localparam logic [1:0] SzRsv = 2'b11;

  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SzB:     misaligned = 1'b0;
      SzH:     misaligned = off[0];
      SzW:     misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Reserved size behaves as a word access when no error is raised.
  function automatic logic [1:0] norm_size(logic [1:0] size);
    norm_size = (size == SzRsv) ? SzW : size;
  endfunction

  function automatic logic [1:0] norm_off(logic [1:0] size, logic [1:0] off);
    case (size)
      SzB:     norm_off = off;
      SzH:     norm_off = {off[1], 1'b0};
      default: norm_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_ctrl_lane_unit.sv
// Byte-lane helper: merges sub-word store data into a read word and extracts/extends
// sub-word load data. Big-endian lanes; size must already be normalised (no reserved code).
module ram_lane_unit
  import ram_arbiter_ctrl_pkg::*;
(
  input  logic [DataBus-1:0] rbuf,
  input  logic [DataBus-1:0] wdata,
  input  logic [1:0]         size,
  input  logic [1:0]         offset,
  input  logic               uns,
  output logic [DataBus-1:0] merged,
  output logic [DataBus-1:0] load_data
);

  logic [4:0]         sh;
  logic [DataBus-1:0] lane_mask;
  logic [DataBus-1:0] raw;

  always_comb begin
    sh        = 5'd0;
    lane_mask = '1;
    case (size)
      SzB: begin
        sh        = {~offset, 3'b000};
        lane_mask = 32'h0000_00ff << sh;
      end
      SzH: begin
        sh        = {~offset[1], 4'b0000};
        lane_mask = 32'h0000_ffff << sh;
      end
      default: ;
    endcase

    merged = (rbuf & ~lane_mask) | ((wdata << sh) & lane_mask);
    raw    = rbuf >> sh;

    case (size)
      SzB:     load_data = uns ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      SzH:     load_data = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      // Word access: sh is zero so raw equals rbuf.
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Two-port round-robin arbiter and load/store sequencer in front of the data RAM.
// Optional alignment/size checking is enabled by defining RAM_ARB_ALIGN_CHK_EN.
module ram_arbiter_ctrl
  import ram_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [1:0]        size0,
  input  logic              uns0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        size1,
  input  logic              uns1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  state_e            state_q, state_d;
  logic              rr_last_q, port_q, we_q, uns_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rbuf_q;
  logic [1:0]        size_q;

  logic              grant_valid, grant;
  logic              sel_we, sel_uns, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant = ~rr_last_q;
    else              grant = ~req0;
    sel_we    = grant ? we1    : we0;
    sel_addr  = grant ? addr1  : addr0;
    sel_wdata = grant ? wdata1 : wdata0;
    sel_size  = grant ? size1  : size0;
    sel_uns   = grant ? uns1   : uns0;
`ifdef RAM_ARB_ALIGN_CHK_EN
    sel_err   = misaligned(sel_size, sel_addr[1:0]);
`else
    sel_err   = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          if (sel_err)                         state_d = StResp;
          else if (!sel_we)                    state_d = StRd;
          else if (norm_size(sel_size) == SzW) state_d = StWr;
          else                                 state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SzB;
      rbuf_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && grant_valid) begin
        rr_last_q <= grant;
        port_q    <= grant;
        we_q      <= sel_we;
        uns_q     <= sel_uns;
        err_q     <= sel_err;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        size_q    <= sel_size;
      end
      if (state_q == StRd) rbuf_q <= ram_rdata;
    end
  end

  logic [1:0]        eff_size, eff_off;
  logic [ADDR_W-1:0] addr_al;
  logic [DATA_W-1:0] merged, load_data, resp_data;
  logic              resp;

  assign eff_size = norm_size(size_q);
  assign eff_off  = norm_off(eff_size, addr_q[1:0]);
  assign addr_al  = {addr_q[ADDR_W-1:WordOffW], WordOffW'(0)};

  ram_lane_unit u_lane (
    .rbuf      (rbuf_q),
    .wdata     (wdata_q),
    .size      (eff_size),
    .offset    (eff_off),
    .uns       (uns_q),
    .merged    (merged),
    .load_data (load_data)
  );

  // Stores and errored accesses return zero data.
  always_comb begin
    ram_re    = (state_q == StRd);
    ram_we    = (state_q == StWr);
    ram_raddr = ram_re ? addr_al : '0;
    ram_waddr = ram_we ? addr_al : '0;
    ram_wdata = ram_we ? merged  : '0;
    resp      = (state_q == StResp);
    resp_data = (err_q || we_q) ? '0 : load_data;
    ack0      = resp & ~port_q;
    ack1      = resp &  port_q;
    rdata0    = ack0 ? resp_data : '0;
    rdata1    = ack1 ? resp_data : '0;
    err0      = ack0 & err_q;
    err1      = ack1 & err_q;
  end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Self-checking bench for ram_arbiter_ctrl: directed vector table, round-robin and reset
// sequences, then random traffic against a byte-array reference model.
module tb_ram_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, uns0, ack0, err0, req1, we1, uns1, ack1, err1;
  logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [1:0]  size0, size1;
  logic        ram_re, ram_we;
  logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;

  always #5 clk = ~clk;

  ram_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0), .uns0(uns0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1), .uns1(uns1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  // 64-byte RAM seen by the DUT, plus the reference byte image.
  logic [31:0] mem [16];
  logic [31:0] init_w [16];
  logic        mem_init;
  logic [7:0]  ref_b [64];

  assign ram_rdata = mem[ram_raddr[5:2]];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 16; i++) mem[i] <= init_w[i];
    else if (ram_we) mem[ram_waddr[5:2]] <= ram_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) chk("re_we_exclusive", {31'd0, ram_re & ram_we}, 32'd0);

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_b[wa], ref_b[wa+1], ref_b[wa+2], ref_b[wa+3]};
  endfunction

  task automatic set_port(input int p, input logic r, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic u);
    if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; size0 = sz; uns0 = u; end
    else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; size1 = sz; uns1 = u; end
  endtask

  // Reference: access rules applied to a byte array; updates ref_b for stores.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u, output logic [31:0] rd,
                       output int lat, output logic er, output int nwe, output int nre,
                       output logic [31:0] wa, output logic [31:0] wd);
    int nb, esz;
    logic [31:0] ea, v;
    esz = (sz == 2'd3) ? 2 : int'(sz);
    ea  = a;
    if (esz == 1) ea[0] = 1'b0;
    if (esz == 2) ea[1:0] = 2'b00;
`ifdef RAM_ARB_ALIGN_CHK_EN
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    er = 1'b0;
`endif
    rd = 0; wa = a & ~32'd3; wd = 0; nwe = 0; nre = 0; lat = 1;
    if (er) return;
    nb = 1 << esz;
    if (!we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[ea+i]);
      if (!u && nb == 1 && v[7])  v = v | 32'hffff_ff00;
      if (!u && nb == 2 && v[15]) v = v | 32'hffff_0000;
      rd = v; lat = 2; nre = 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[ea+i] = d[8*(nb-1-i) +: 8];
      lat = (nb == 4) ? 2 : 3;
      nre = (nb == 4) ? 0 : 1;
      nwe = 1;
      wd  = ref_word(int'(wa));
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, output logic [31:0] rd,
                        output int lat, output logic er, output int nwe, output int nre,
                        output logic [31:0] wa, output logic [31:0] wd);
    set_port(p, 1'b1, we, a, d, sz, u);
    lat = 0; nwe = 0; nre = 0; rd = 0; er = 0; wa = 0; wd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ram_we) begin nwe++; wa = ram_waddr; wd = ram_wdata; end
      if (ram_re) nre++;
      chk("other_ack", {31'd0, (p == 0) ? ack1 : ack0}, 32'd0);
      if ((p == 0) ? ack0 : ack1) begin
        lat = c;
        rd  = (p == 0) ? rdata0 : rdata1;
        er  = (p == 0) ? err0 : err1;
        chk("other_rdata", (p == 0) ? rdata1 : rdata0, 32'd0);
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout port %0d got no ack want ack within 10 cycles", p);
    end
    set_port(p, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_model(input int p, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic u);
    logic [31:0] e_rd, e_wa, e_wd, rd, wa, wd;
    int e_lat, e_nwe, e_nre, lat, nwe, nre;
    logic e_er, er;
    model(we, a, d, sz, u, e_rd, e_lat, e_er, e_nwe, e_nre, e_wa, e_wd);
    do_txn(p, we, a, d, sz, u, rd, lat, er, nwe, nre, wa, wd);
    chk("rnd_latency", lat, e_lat);
    chk("rnd_err", {31'd0, er}, {31'd0, e_er});
    chk("rnd_we_pulses", nwe, e_nwe);
    chk("rnd_re_pulses", nre, e_nre);
    if (!we) chk("rnd_rdata", rd, e_rd);
    if (e_nwe == 1) begin
      chk("rnd_waddr", wa, e_wa);
      chk("rnd_wdata", wd, e_wd);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [11];
  int   order [$];

  initial begin
    logic [31:0] m_rd, m_wa, m_wd, rd, wa, wd;
    int m_lat, m_nwe, m_nre, lat, nwe, nre;
    logic m_er, er;

    vecs[0]  = '{0, 1'b1, 32'h10, 32'hdead_beef, 2'd2, 1'b0, 32'h0,         2, 1'b0, 32'hdead_beef};
    vecs[1]  = '{0, 1'b0, 32'h10, 32'h0,         2'd2, 1'b0, 32'hdead_beef, 2, 1'b0, 32'h0};
    vecs[2]  = '{0, 1'b1, 32'h11, 32'h55,        2'd0, 1'b0, 32'h0,         3, 1'b0, 32'hde55_beef};
    vecs[3]  = '{0, 1'b0, 32'h10, 32'h0,         2'd2, 1'b0, 32'hde55_beef, 2, 1'b0, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h13, 32'h0,         2'd0, 1'b0, 32'hffff_ffef, 2, 1'b0, 32'h0};
    vecs[5]  = '{0, 1'b0, 32'h13, 32'h0,         2'd0, 1'b1, 32'h0000_00ef, 2, 1'b0, 32'h0};
    vecs[6]  = '{1, 1'b1, 32'h20, 32'h1234_8001, 2'd2, 1'b0, 32'h0,         2, 1'b0, 32'h1234_8001};
    vecs[7]  = '{1, 1'b0, 32'h22, 32'h0,         2'd1, 1'b0, 32'hffff_8001, 2, 1'b0, 32'h0};
    vecs[8]  = '{1, 1'b0, 32'h22, 32'h0,         2'd1, 1'b1, 32'h0000_8001, 2, 1'b0, 32'h0};
`ifdef RAM_ARB_ALIGN_CHK_EN
    vecs[9]  = '{0, 1'b0, 32'h13, 32'h0,         2'd2, 1'b0, 32'h0,         1, 1'b1, 32'h0};
`else
    vecs[9]  = '{0, 1'b0, 32'h13, 32'h0,         2'd2, 1'b0, 32'hde55_beef, 2, 1'b0, 32'h0};
`endif
    vecs[10] = '{1, 1'b1, 32'h20, 32'hffff_abcd, 2'd1, 1'b0, 32'h0,         3, 1'b0, 32'habcd_8001};

    for (int i = 0; i < 16; i++) begin
      init_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i+b] = init_w[i][31-8*b -: 8];
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    rst_n    = 1'b0;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_raddr", ram_raddr, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Both ports held from reset: port 0 wins the first tie, then alternation.
    set_port(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
    set_port(1, 1'b1, 1'b0, 32'h14, 32'd0, 2'd2, 1'b0);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      chk("rr_single_ack", {31'd0, ack0 & ack1}, 32'd0);
      if (ack0) begin order.push_back(0); chk("rr_rdata0", rdata0, ref_word(32'h10)); end
      if (ack1) begin order.push_back(1); chk("rr_rdata1", rdata1, ref_word(32'h14)); end
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    if (order.size() < 4) begin
      checks++; errors++;
      $display("FAIL rr_count got %0d acks want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
    end

    for (int i = 0; i < 11; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
            m_rd, m_lat, m_er, m_nwe, m_nre, m_wa, m_wd);
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
             rd, lat, er, nwe, nre, wa, wd);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_we_pulses", i), nwe, 0);
        chk($sformatf("vec%0d_re_pulses", i), nre, vecs[i].exp_err ? 0 : 1);
      end else begin
        chk($sformatf("vec%0d_we_pulses", i), nwe, 1);
        chk($sformatf("vec%0d_waddr", i), wa, vecs[i].addr & ~32'd3);
        chk($sformatf("vec%0d_wdata", i), wd, vecs[i].exp_wdata);
      end
    end

    // Reset during the RD phase of a byte store: no ack, no write, word untouched.
    set_port(0, 1'b1, 1'b1, 32'h11, 32'h77, 2'd0, 1'b0);
    @(negedge clk);
    chk("abort_in_rd", {31'd0, ram_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
    chk("abort_ack0", {31'd0, ack0}, 32'd0);
    chk("abort_ram_re", {31'd0, ram_re}, 32'd0);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_ack0_hold", {31'd0, ack0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_unchanged", mem[4], ref_word(32'h10));
    run_model(1, 1'b0, 32'h11, 32'd0, 2'd0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      run_model(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 16; i++) chk($sformatf("mem_final%0d", i), mem[i], ref_word(4*i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
